// File: rtl/neuron_mac_pkg.sv
// Shared constants and FSM state type for the single-neuron MAC stage.
// The saturating output stage reuses the same operand format constants.
package neuron_mac_pkg;

  localparam int WEIGHT_WIDTH = 16;
  localparam int FRAC_BITS    = 8;
  localparam int NUM_INPUTS   = 784;
  localparam int ACC_WIDTH    = 40;
  localparam int CNT_WIDTH    = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    BIAS = 3'd2,
    SAT  = 3'd3,
    OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/neuron_mac_if.sv
// Control, input-stream and output-stream handshake bundle for neuron_mac.
// The master side is the upstream feeder plus the downstream activation stage.
interface neuron_mac_if
  import neuron_mac_pkg::*;
#(
  parameter int WIDTH = WEIGHT_WIDTH
);

  logic                    start;
  logic signed [WIDTH-1:0] bias;
  logic                    busy;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic signed [WIDTH-1:0] in_weight;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;

  modport master (
    output start, bias, in_valid, in_data, in_weight, out_ready,
    input  busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  start, bias, in_valid, in_data, in_weight, out_ready,
    output busy, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/neuron_mac_saturate.sv
// Rescales a Q(2F) accumulator back to Q(F) (floor shift, no rounding) and
// clamps it into a WIDTH-bit signed result; also used by the output layer.
module neuron_saturate
  import neuron_mac_pkg::*;
#(
  parameter int WIDTH = WEIGHT_WIDTH,
  parameter int FRAC  = FRAC_BITS,
  parameter int ACC_W = ACC_WIDTH
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] result
);

  localparam logic signed [ACC_W-1:0] MAX_VAL =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_VAL =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc >>> FRAC;

  always_comb begin
    result = shifted[WIDTH-1:0];
    if (shifted > MAX_VAL) begin
      result = MAX_VAL[WIDTH-1:0];
    end else if (shifted < MIN_VAL) begin
      result = MIN_VAL[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams N_INPUTS (activation, weight)
// pairs, adds the bias, rescales and saturates, then hands one result downstream.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int WIDTH    = WEIGHT_WIDTH,
  parameter int FRAC     = FRAC_BITS,
  parameter int N_INPUTS = NUM_INPUTS,
  parameter int ACC_W    = ACC_WIDTH,
  parameter int CNT_W    = CNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  neuron_mac_if.slave  bus
);

  state_t state;
  state_t next_state;

  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          count;
  logic signed [WIDTH-1:0]   bias_q;
  logic signed [WIDTH-1:0]   out_data;
  logic signed [WIDTH-1:0]   sat_data;
  logic                      out_valid;
  logic                      beat;
  logic                      last_beat;
  logic signed [2*WIDTH-1:0] product;
  logic signed [ACC_W-1:0]   product_ext;
  logic signed [ACC_W-1:0]   bias_ext;

  assign bus.in_ready  = (state == ACC);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

  assign beat      = bus.in_valid && (state == ACC);
  assign last_beat = (count == CNT_W'(N_INPUTS - 1));

  // Full-precision product, sign-extended; bias is lifted into Q(2F) by the zero tail.
  assign product     = bus.in_data * bus.in_weight;
  assign product_ext = {{(ACC_W-2*WIDTH){product[2*WIDTH-1]}}, product};
  assign bias_ext    = {{(ACC_W-WIDTH-FRAC){bias_q[WIDTH-1]}}, bias_q, {FRAC{1'b0}}};

  neuron_saturate #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_saturate (
    .acc    (acc),
    .result (sat_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = ACC;
      ACC:  if (beat && last_beat) next_state = BIAS;
      BIAS: next_state = SAT;
      SAT:  next_state = OUT;
      OUT:  if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers follow the same state decode as the FSM above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      bias_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            count  <= '0;
            bias_q <= bus.bias;
          end
        end
        ACC: begin
          if (beat) begin
            acc   <= acc + product_ext;
            count <= count + 1'b1;
          end
        end
        BIAS: begin
          acc <= acc + bias_ext;
        end
        SAT: begin
          out_data  <= sat_data;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
